// File: rtl/fsk_bit_decoder.sv
// FSK bit decoder: per-window deltas of the analyzer's tick counters,
// one bit decision per window, word assembly and a valid/ready output.
module fsk_bit_decoder #(
  parameter int unsigned BIT_PERIOD_TICKS   = 50000,
  parameter int unsigned MIN_ACTIVITY_TICKS = 5000,
  parameter int unsigned DATA_WIDTH         = 8,
  parameter bit          MSB_FIRST          = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [31:0]           f0_value,
  input  logic [31:0]           f1_value,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  bit_value,
  output logic                  bit_valid,
  output logic                  carrier_lost,
  output logic                  overrun
);

  localparam int unsigned CNT_W  = $clog2(BIT_PERIOD_TICKS);
  localparam int unsigned BCNT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned SUM_W  = 33;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           f0_prev_q, f0_prev_d;
  logic [31:0]           f1_prev_q, f1_prev_d;
  logic [31:0]           d0_q, d0_d;
  logic [31:0]           d1_q, d1_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  bit_value_q, bit_value_d;
  logic                  bit_valid_q, bit_valid_d;
  logic                  carrier_lost_q, carrier_lost_d;
  logic                  overrun_q, overrun_d;

  logic                  window_end_c;
  logic [SUM_W-1:0]      sum_c;
  logic                  bit_c;
  logic [DATA_WIDTH-1:0] word_c;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enable starts (priming) and stops decoding
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window timing, delta capture, bit decision, word assembly and handshake
  always_comb begin
    cnt_d          = cnt_q;
    f0_prev_d      = f0_prev_q;
    f1_prev_d      = f1_prev_q;
    d0_d           = d0_q;
    d1_d           = d1_q;
    s1_vld_d       = 1'b0;
    bcnt_d         = bcnt_q;
    shreg_d        = shreg_q;
    data_d         = data_q;
    data_valid_d   = data_valid_q;
    bit_value_d    = bit_value_q;
    bit_valid_d    = 1'b0;
    carrier_lost_d = 1'b0;
    overrun_d      = overrun_q;

    window_end_c = (state_q == RUN) && enable &&
                   (cnt_q == CNT_W'(BIT_PERIOD_TICKS - 1));
    sum_c  = {1'b0, d0_q} + {1'b0, d1_q};
    bit_c  = (d1_q > d0_q);
    if (MSB_FIRST) begin
      word_c = (shreg_q << 1) | DATA_WIDTH'(bit_c);
    end else begin
      word_c = (shreg_q >> 1) | (DATA_WIDTH'(bit_c) << (DATA_WIDTH - 1));
    end

    // Stage 1: window counter and modulo-2^32 deltas at the window end
    case (state_q)
      IDLE: begin
        if (enable) begin
          f0_prev_d = f0_value;
          f1_prev_d = f1_value;
          cnt_d     = '0;
          bcnt_d    = '0;
          shreg_d   = '0;
        end
      end
      RUN: begin
        if (enable) begin
          if (window_end_c) begin
            cnt_d     = '0;
            d0_d      = f0_value - f0_prev_q;
            d1_d      = f1_value - f1_prev_q;
            f0_prev_d = f0_value;
            f1_prev_d = f1_value;
            s1_vld_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          bcnt_d  = '0;
          shreg_d = '0;
        end
      end
      default: ;
    endcase

    // Output handshake: a transfer empties the output register
    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    // Stage 2: decision; runs even if enable dropped after the window end
    if (s1_vld_q) begin
      if (sum_c < SUM_W'(MIN_ACTIVITY_TICKS)) begin
        carrier_lost_d = 1'b1;
        bcnt_d         = '0;
        shreg_d        = '0;
      end else begin
        bit_value_d = bit_c;
        bit_valid_d = 1'b1;
        if (bcnt_q == BCNT_W'(DATA_WIDTH - 1)) begin
          bcnt_d  = '0;
          shreg_d = '0;
          if (!data_valid_q || data_ready) begin
            data_d       = word_c;
            data_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          bcnt_d  = bcnt_q + BCNT_W'(1);
          shreg_d = word_c;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q          <= '0;
      f0_prev_q      <= '0;
      f1_prev_q      <= '0;
      d0_q           <= '0;
      d1_q           <= '0;
      s1_vld_q       <= 1'b0;
      bcnt_q         <= '0;
      shreg_q        <= '0;
      data_q         <= '0;
      data_valid_q   <= 1'b0;
      bit_value_q    <= 1'b0;
      bit_valid_q    <= 1'b0;
      carrier_lost_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      f0_prev_q      <= f0_prev_d;
      f1_prev_q      <= f1_prev_d;
      d0_q           <= d0_d;
      d1_q           <= d1_d;
      s1_vld_q       <= s1_vld_d;
      bcnt_q         <= bcnt_d;
      shreg_q        <= shreg_d;
      data_q         <= data_d;
      data_valid_q   <= data_valid_d;
      bit_value_q    <= bit_value_d;
      bit_valid_q    <= bit_valid_d;
      carrier_lost_q <= carrier_lost_d;
      overrun_q      <= overrun_d;
    end
  end

  assign data         = data_q;
  assign data_valid   = data_valid_q;
  assign bit_value    = bit_value_q;
  assign bit_valid    = bit_valid_q;
  assign carrier_lost = carrier_lost_q;
  assign overrun      = overrun_q;

endmodule
